// File: rtl/bound_stream_reducer.sv
// Streaming bound reducer: folds a valid/ready stream of signed constraint candidates
// into the tightest [lower, upper] interval for one variable and offers it on a result port.
module bound_stream_reducer #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               cand_valid,
   output logic               cand_ready,
   input  logic [WIDTH-1:0]   cand_value,
   input  logic               cand_activation,
   input  logic               cand_sign,
   input  logic               cand_last,
   output logic [WIDTH:0]     lower_bound,
   output logic               lower_valid,
   output logic [WIDTH:0]     upper_bound,
   output logic               upper_valid,
   output logic               infeasible,
   output logic [COUNT_W-1:0] cand_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic [1:0]         state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // a producer holding valid keeps its payload stable until that edge, and ready
   // never depends combinationally on valid (both ready and out_valid are flops).

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state;

   logic                accept;
   logic signed [WIDTH:0] cand_ext;
   logic signed [WIDTH:0] cand_neg;
   logic signed [WIDTH:0] lower_s;
   logic signed [WIDTH:0] upper_s;
   logic                lower_take;
   logic                upper_take;

   assign accept   = cand_valid & cand_ready;
   // One extra bit so negating the most negative candidate stays exact.
   assign cand_ext = {cand_value[WIDTH-1], cand_value};
   assign cand_neg = -cand_ext;
   assign lower_s  = lower_bound;
   assign upper_s  = upper_bound;

   // Strict compares: an equal candidate leaves the bound untouched.
   assign lower_take = cand_activation & cand_sign &
                       (~lower_valid | (cand_neg > lower_s));
   assign upper_take = cand_activation & ~cand_sign &
                       (~upper_valid | (cand_ext < upper_s));

   assign infeasible = lower_valid & upper_valid & (lower_s > upper_s);
   assign busy       = (state != S_IDLE);
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         lower_bound <= '0;
         lower_valid <= 1'b0;
         upper_bound <= '0;
         upper_valid <= 1'b0;
         cand_count  <= '0;
         cand_ready  <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_ACCUM;
                  cand_ready  <= 1'b1;
                  lower_bound <= '0;
                  lower_valid <= 1'b0;
                  upper_bound <= '0;
                  upper_valid <= 1'b0;
                  cand_count  <= '0;
               end
            end

            S_ACCUM: begin
               if (accept) begin
                  if (cand_count != {COUNT_W{1'b1}}) begin
                     cand_count <= cand_count + 1'b1;
                  end
                  if (lower_take) begin
                     lower_bound <= cand_neg;
                  end
                  if (cand_activation & cand_sign) begin
                     lower_valid <= 1'b1;
                  end
                  if (upper_take) begin
                     upper_bound <= cand_ext;
                  end
                  if (cand_activation & ~cand_sign) begin
                     upper_valid <= 1'b1;
                  end
                  if (cand_last) begin
                     state      <= S_DONE;
                     cand_ready <= 1'b0;
                     out_valid  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end

            default: begin
               state      <= S_IDLE;
               cand_ready <= 1'b0;
               out_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bound_stream_reducer.sv
// Bench for bound_stream_reducer: directed scenarios plus random reductions checked
// against an interval model computed from the whole candidate list of each reduction.
module tb_bound_stream_reducer;

   localparam int WIDTH   = 8;
   localparam int COUNT_W = 4;
   localparam int CNT_MAX = (1 << COUNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               cand_valid;
   logic               cand_ready;
   logic [WIDTH-1:0]   cand_value;
   logic               cand_activation;
   logic               cand_sign;
   logic               cand_last;
   logic [WIDTH:0]     lower_bound;
   logic               lower_valid;
   logic [WIDTH:0]     upper_bound;
   logic               upper_valid;
   logic               infeasible;
   logic [COUNT_W-1:0] cand_count;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic [1:0]         state_dbg;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int v;
      bit a;
      bit s;
   } cand_t;

   cand_t cand_q[$];

   bound_stream_reducer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_value(cand_value),
      .cand_activation(cand_activation), .cand_sign(cand_sign), .cand_last(cand_last),
      .lower_bound(lower_bound), .lower_valid(lower_valid),
      .upper_bound(upper_bound), .upper_valid(upper_valid),
      .infeasible(infeasible), .cand_count(cand_count),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // all steps begin and end right after a falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // driver tasks
   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      cand_q.delete();
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_ready", {31'd0, cand_ready}, 32'd1);
   endtask

   task automatic send(input int v, input bit a, input bit s, input bit last);
      int budget;
      budget = 20;
      cand_value      = v[WIDTH-1:0];
      cand_activation = a;
      cand_sign       = s;
      cand_last       = last;
      cand_valid      = 1'b1;
      while (!cand_ready && budget > 0) begin
         step();
         budget--;
      end
      if (budget == 0) chk("ready_timeout", {31'd0, cand_ready}, 32'd1);
      step();
      cand_valid = 1'b0;
      cand_last  = 1'b0;
      cand_q.push_back('{v: v, a: a, s: s});
   endtask

   // scoreboard: interval derived from the whole candidate list
   task automatic check_result(input string tag);
      int lo, hi, n;
      bit lv, uv;
      logic [WIDTH:0] lo9, hi9;
      lo = 0; hi = 0; lv = 0; uv = 0;
      n = cand_q.size();
      foreach (cand_q[i]) begin
         if (cand_q[i].a && cand_q[i].s) begin
            if (!lv || -cand_q[i].v > lo) lo = -cand_q[i].v;
            lv = 1;
         end else if (cand_q[i].a) begin
            if (!uv || cand_q[i].v < hi) hi = cand_q[i].v;
            uv = 1;
         end
      end
      lo9 = lo[WIDTH:0];
      hi9 = hi[WIDTH:0];
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_cand_ready"}, {31'd0, cand_ready}, 32'd0);
      chk({tag, "_lower_valid"}, {31'd0, lower_valid}, {31'd0, lv});
      chk({tag, "_upper_valid"}, {31'd0, upper_valid}, {31'd0, uv});
      chk({tag, "_lower"}, {23'd0, lower_bound}, {23'd0, lo9});
      chk({tag, "_upper"}, {23'd0, upper_bound}, {23'd0, hi9});
      chk({tag, "_infeasible"}, {31'd0, infeasible}, {31'd0, (lv && uv && lo > hi)});
      chk({tag, "_count"}, {28'd0, cand_count}, (n > CNT_MAX) ? CNT_MAX : n);
   endtask

   task automatic take_result(input string tag);
      logic [WIDTH:0] lb;
      lb = lower_bound;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hold_lower"}, {23'd0, lower_bound}, {23'd0, lb});
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ready"}, {31'd0, cand_ready}, 32'd0);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_bounds"}, {14'd0, lower_bound, upper_bound}, 32'd0);
      chk({tag, "_valids"}, {30'd0, lower_valid, upper_valid}, 32'd0);
      chk({tag, "_count"}, {28'd0, cand_count}, 32'd0);
      chk({tag, "_infeasible"}, {31'd0, infeasible}, 32'd0);
   endtask

   initial begin
      logic [COUNT_W-1:0] cnt_hold;
      reset = 1'b1; start = 1'b0; cand_valid = 1'b0; cand_value = '0;
      cand_activation = 1'b0; cand_sign = 1'b0; cand_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      repeat (3) step();
      check_reset_values("reset");
      reset = 1'b0;
      step();

      // T1
      do_start();
      send(5, 1, 1, 0);
      send(-3, 1, 1, 0);
      send(20, 1, 0, 0);
      send(9, 1, 0, 1);
      check_result("t1");
      chk("t1_lower_const", {23'd0, lower_bound}, 32'd3);
      chk("t1_upper_const", {23'd0, upper_bound}, 32'd9);
      take_result("t1");

      // candidates in IDLE are ignored
      cnt_hold = cand_count;
      cand_valid = 1'b1; cand_activation = 1'b1; cand_value = 8'd100;
      repeat (3) step();
      cand_valid = 1'b0;
      chk("idle_ignore_count", {28'd0, cand_count}, {28'd0, cnt_hold});
      chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

      // T2
      do_start();
      send(-128, 1, 1, 1);
      check_result("t2");
      chk("t2_lower_const", {23'd0, lower_bound}, 32'd128);
      take_result("t2");

      // T3
      do_start();
      send(2, 1, 0, 0);
      send(-7, 1, 1, 1);
      check_result("t3a");
      chk("t3a_infeasible_const", {31'd0, infeasible}, 32'd1);
      take_result("t3a");
      do_start();
      send(4, 1, 1, 0);
      send(-4, 1, 0, 1);
      check_result("t3b");
      chk("t3b_equal_feasible", {31'd0, infeasible}, 32'd0);
      take_result("t3b");

      // T4
      do_start();
      send(11, 0, 1, 0);
      send(-50, 0, 0, 0);
      send(77, 0, 1, 1);
      check_result("t4");
      take_result("t4");

      // T5: result held while consumer stalls
      do_start();
      send(-10, 1, 1, 0);
      send(30, 1, 0, 1);
      check_result("t5");
      cand_valid = 1'b1; cand_last = 1'b1; cand_activation = 1'b1; cand_value = 8'h80;
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         step();
         chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("t5_hold_ready", {31'd0, cand_ready}, 32'd0);
         chk("t5_hold_count", {28'd0, cand_count}, 32'd2);
      end
      start = 1'b0; cand_valid = 1'b0; cand_last = 1'b0;
      check_result("t5_after_stall");
      take_result("t5");

      // T6: abort by reset, then counter saturation
      do_start();
      send(1, 1, 1, 0);
      send(2, 1, 0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_values("t6_abort");
      do_start();
      for (int i = 0; i < 20; i++) send($urandom_range(0, 255), 0, $urandom_range(0, 1), i == 19);
      check_result("t6_sat");
      chk("t6_sat_const", {28'd0, cand_count}, 32'd15);
      take_result("t6");

      // random reductions with idle gaps between candidates
      for (int r = 0; r < 40; r++) begin
         int len;
         len = $urandom_range(1, 18);
         do_start();
         for (int i = 0; i < len; i++) begin
            int v;
            v = $urandom_range(0, 255);
            if (v > 127) v = v - 256;
            if ($urandom_range(0, 3) == 0) step();
            send(v, $urandom_range(0, 3) != 0, $urandom_range(0, 1), i == len - 1);
         end
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
         check_result("rand");
         take_result("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
